// File: rtl/jk_bank_ctrl_if.sv
// jk_bank_ctrl_if: command handshake and JK bank bus between command source, controller and cells
interface jk_bank_ctrl_if #(parameter int WIDTH = 4);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic [WIDTH-1:0] q_in;
    logic             busy;
    logic             done;
    logic             wrap;
    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, q_in,
        output cmd_ready, j_out, k_out, busy, done, wrap
    );
    modport master (
        output cmd_valid, cmd_op, cmd_arg, q_in,
        input  cmd_ready, j_out, k_out, busy, done, wrap
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: sequences a bank of reset-less JK cells (clear, masked set/clear/toggle, count); JK_BANK_SAT_EN makes COUNT saturate
module jk_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    jk_bank_ctrl_if.slave bus
);
    localparam logic [1:0] OP_SET    = 2'd0;
    localparam logic [1:0] OP_CLEAR  = 2'd1;
    localparam logic [1:0] OP_TOGGLE = 2'd2;
    localparam logic [1:0] OP_COUNT  = 2'd3;

    typedef enum logic [2:0] {
        S_RESET, S_INIT, S_IDLE, S_APPLY, S_COUNT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] t;
    logic             all_ones;

    assign all_ones = &bus.q_in;

    // state register: reset forces RESET so release always passes through INIT
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_RESET;
        else
            state_q <= state_d;
    end

    // command latches: only change on a handshake or while counting
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        arg_q <= arg_d;
        cnt_q <= cnt_d;
    end

    // next state and latch updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT:  state_d = S_IDLE;
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    arg_d   = bus.cmd_arg;
                    cnt_d   = bus.cmd_arg;
                    state_d = (bus.cmd_op != OP_COUNT) ? S_APPLY :
                              (bus.cmd_arg == '0)      ? S_DONE  : S_COUNT;
                end
            end
            S_APPLY: state_d = S_DONE;
            S_COUNT: begin
                cnt_d = cnt_q - WIDTH'(1);
`ifdef JK_BANK_SAT_EN
                state_d = (cnt_q == WIDTH'(1) || all_ones) ? S_DONE : S_COUNT;
`else
                state_d = (cnt_q == WIDTH'(1)) ? S_DONE : S_COUNT;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_RESET;
        endcase
    end

    // output decode: J/K from state, latched mask and fed-back Q; status from state
    always_comb begin
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++)
            t[i] = t[i-1] & bus.q_in[i-1];
        bus.j_out = '0;
        bus.k_out = '0;
        case (state_q)
            S_INIT: bus.k_out = '1;
            S_APPLY: begin
                bus.j_out = (op_q == OP_SET || op_q == OP_TOGGLE) ? arg_q : '0;
                bus.k_out = (op_q == OP_CLEAR || op_q == OP_TOGGLE) ? arg_q : '0;
            end
            S_COUNT: begin
`ifdef JK_BANK_SAT_EN
                bus.j_out = all_ones ? '0 : t;
                bus.k_out = all_ones ? '0 : t;
`else
                bus.j_out = t;
                bus.k_out = t;
`endif
            end
            default: ;
        endcase
        if (!rst_n) begin
            bus.j_out = '0;
            bus.k_out = '0;
        end
        bus.cmd_ready = rst_n && state_q == S_IDLE;
        bus.busy      = rst_n && state_q != S_IDLE && state_q != S_RESET;
        bus.done      = rst_n && state_q == S_DONE;
`ifdef JK_BANK_SAT_EN
        bus.wrap      = 1'b0;
`else
        bus.wrap      = rst_n && state_q == S_COUNT && all_ones;
`endif
    end
endmodule
